// File: rtl/lsu_pkg.sv
// Shared LSU definitions: width codes, error codes, FSM states and request decode helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK         = 2'd0,
        ERR_MISALIGNED = 2'd1,
        ERR_ILLEGAL    = 2'd2,
        ERR_TIMEOUT    = 2'd3
    } err_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths only make sense for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load lane extraction: shifts the addressed lane down and sign/zero extends by width code.
// Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = 2
) (
    input  logic [XLEN-1:0]  rdata_i,
    input  logic [OFF_W-1:0] off_i,
    input  logic [2:0]       funct3_i,
    output logic [XLEN-1:0]  data_o
);

    logic [XLEN-1:0] lane;
    logic            sgn;

    always_comb begin
        lane   = rdata_i >> {off_i, 3'b000};
        sgn    = 1'b0;
        data_o = lane;
        case (funct3_i[1:0])
            2'b00: begin
                sgn    = lane[7] & ~funct3_i[2];
                data_o = {{(XLEN-8){sgn}}, lane[7:0]};
            end
            2'b01: begin
                sgn    = lane[15] & ~funct3_i[2];
                data_o = {{(XLEN-16){sgn}}, lane[15:0]};
            end
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes and checks a request on accept, drives one memory access,
// then emits a single-cycle response with extended data or an error code.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic [1:0]          rsp_err,
    output logic                mem_r_en,
    output logic                mem_w_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_w_data,
    output logic [XLEN/8-1:0]   mem_w_strb,
    input  logic [XLEN-1:0]     mem_r_data,
    input  logic                mem_ack
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_t             state_q;
    logic               ready_q;
    logic [7:0]         cnt_q;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [OFF_W-1:0]   off_q;
    logic               rsp_valid_q;
    logic [XLEN-1:0]    rsp_rdata_q;
    logic [1:0]         rsp_err_q;
    logic               mem_r_en_q;
    logic               mem_w_en_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [XLEN-1:0]    mem_w_data_q;
    logic [NB-1:0]      mem_w_strb_q;

    logic [1:0]         err_d;
    logic [OFF_W-1:0]   off_d;
    logic [NB-1:0]      strb_d;
    logic [XLEN-1:0]    wdata_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [XLEN-1:0]    ld_data;

    assign off_d  = req_addr[OFF_W-1:0];
    assign addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        err_d = ERR_OK;
        if (!f3_legal(req_we, req_funct3))
            err_d = ERR_ILLEGAL;
        else if (f3_misaligned(req_funct3, req_addr[1:0]))
            err_d = ERR_MISALIGNED;

        strb_d  = '0;
        wdata_d = '0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    strb_d  = NB'(1) << off_d;
                    wdata_d = {NB{req_wdata[7:0]}};
                end
                2'b01: begin
                    strb_d  = NB'(3) << off_d;
                    wdata_d = {(NB/2){req_wdata[15:0]}};
                end
                default: begin
                    strb_d  = '1;
                    wdata_d = req_wdata;
                end
            endcase
        end
    end

    lsu_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
        .rdata_i  (mem_r_data),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= ERR_OK;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_w_data_q <= '0;
            mem_w_strb_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The request check happens on this accept edge; no separate cycle.
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (req_valid) begin
                        ready_q <= 1'b0;
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= off_d;
                        if (err_d == ERR_OK) begin
                            state_q      <= ST_ACCESS;
                            cnt_q        <= '0;
                            mem_r_en_q   <= !req_we;
                            mem_w_en_q   <= req_we;
                            mem_addr_q   <= addr_d;
                            mem_w_data_q <= wdata_d;
                            mem_w_strb_q <= strb_d;
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= err_d;
                            rsp_rdata_q <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack || cnt_q == 8'(TIMEOUT - 1)) begin
                        state_q      <= ST_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_err_q    <= mem_ack ? ERR_OK : ERR_TIMEOUT;
                        rsp_rdata_q  <= (mem_ack && !we_q) ? ld_data : '0;
                        mem_r_en_q   <= 1'b0;
                        mem_w_en_q   <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_w_data_q <= '0;
                        mem_w_strb_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= ERR_OK;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign mem_r_en   = mem_r_en_q;
    assign mem_w_en   = mem_w_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_w_data = mem_w_data_q;
    assign mem_w_strb = mem_w_strb_q;

endmodule
